// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one pipelined sigmoid ROM among NUM_REQ requesters.
// A one-hot tag rides a shift pipeline alongside the ROM read so each result returns to its issuer.
module sig_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int inWidth   = 10,
  parameter int dataWidth = 16,
  parameter int ROM_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*inWidth-1:0] req_x,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [dataWidth-1:0]       resp_data,
  output logic [inWidth-1:0]         rom_x,
  input  logic [dataWidth-1:0]       rom_out,
  output logic                       busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                ptr_q, ptr_d, win;
  logic                            found, accept;
  logic [NUM_REQ-1:0]              gnt;
  logic [inWidth-1:0]              win_x;
  logic [inWidth-1:0]              rom_x_q, rom_x_d;
  logic [dataWidth-1:0]            resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]              resp_valid_q, resp_valid_d;
  logic [ROM_LAT:0][NUM_REQ-1:0]   tag_q, tag_d;

  function automatic int rot(input int p, input int k);
    rot = (p + k) % NUM_REQ;
  endfunction

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_x = '0;
    gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rot(int'(ptr_q), k)]) begin
        found = 1'b1;
        win   = PTR_W'(rot(int'(ptr_q), k));
        win_x = req_x[rot(int'(ptr_q), k)*inWidth +: inWidth];
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  assign req_ready = rst ? '0 : gnt;
  assign accept    = |req_ready;

  always_comb begin
    ptr_d        = ptr_q;
    rom_x_d      = rom_x_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = tag_q[ROM_LAT];
    tag_d        = '0;
    if (accept) begin
      ptr_d   = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
      rom_x_d = win_x;
    end
    tag_d[0] = req_ready;
    for (int s = 1; s <= ROM_LAT; s++) tag_d[s] = tag_q[s-1];
    // Last tag stage lines up with valid ROM read data
    if (|tag_q[ROM_LAT]) resp_data_d = rom_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      rom_x_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
      tag_q        <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rom_x_q      <= rom_x_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      tag_q        <= tag_d;
    end
  end

  assign rom_x      = rom_x_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = |tag_q;

endmodule

// File: doc/sig_rom_arbiter.md
Name: sig_rom_arbiter

Overview:
- Shares one sigmoid lookup ROM among NUM_REQ neuron activation requesters.
- Uses round-robin arbitration, fully pipelined at one lookup per cycle.
- Each accepted lookup carries a one-hot tag through a shift pipeline matched to the ROM read latency. The looked-up value returns to the requester that issued it.
- Sits between the neuron array and a single shared sigmoid ROM instance (registered address, read data valid ROM_LAT cycles later).

Parameters:
- NUM_REQ, 4, number of requesting neurons (>=1).
- inWidth, 10, activation address width; matches the ROM x port.
- dataWidth, 16, sigmoid output width; matches the ROM out port.
- ROM_LAT, 1, cycles from rom_x being driven until rom_out is valid.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  bit i: requester i has a lookup pending
- req_x  input  NUM_REQ*inWidth  packed addresses, slice i = [i*inWidth +: inWidth]
- req_ready  output  NUM_REQ  one-hot grant; combinational in the cycle of acceptance
- resp_valid  output  NUM_REQ  one-hot, one-cycle pulse: resp_data belongs to requester i
- resp_data  output  dataWidth  registered sigmoid value
- rom_x  output  inWidth  registered address to the shared ROM
- rom_out  input  dataWidth  ROM read data
- busy  output  1  high while any lookup is in flight

Behaviour:
- Reset (async, rst=1):
  - rom_x=0, resp_data=0, resp_valid=0, tag pipeline=0, busy=0.
  - Round-robin pointer=0.
  - req_ready=0 while rst is high.
  - In-flight lookups are discarded; no response pulse is produced for them after reset release.
- Arbitration (combinational, every cycle):
  - Winner w = first i with req_valid[i]=1, searching i = ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready = onehot(w) if any req_valid, else 0. Never more than one bit set.
- Handshake:
  - A lookup is accepted when req_valid[i] & req_ready[i].
  - The requester holds req_valid and req_x stable until accepted.
  - The requester may re-assert for a new lookup in the very next cycle.
  - Dropping req_valid before acceptance withdraws the request with no side effect.
- Pointer update: on acceptance, ptr <= (w+1) mod NUM_REQ. With no acceptance, ptr holds.
- Issue: on acceptance at edge E, rom_x <= req_x[w] and tag stage 0 <= onehot(w). Without acceptance, rom_x holds its value and stage 0 <= 0.
- Tag pipeline:
  - Stages 0..ROM_LAT shift every cycle, unconditionally; there is no stall or backpressure.
  - Stage ROM_LAT is aligned with valid rom_out.
  - At the next edge: resp_data <= rom_out and resp_valid <= stage ROM_LAT.
  - When stage ROM_LAT is 0, resp_data holds its previous value.
- Latency:
  - Accepted in cycle C -> resp_valid/resp_data visible in cycle C+ROM_LAT+2 (C+3 at default).
  - Throughput is 1 lookup per cycle; responses return in acceptance order.
- busy = OR of all tag stages.
  - Does not include the current-cycle grant.
  - Does not include the cycle in which resp_valid is high.
- Boundaries:
  - All requesters valid continuously: grants rotate ptr, ptr+1, ...; each requester is served once per NUM_REQ cycles.
  - Same requester back-to-back (only one valid): granted every cycle; NUM_REQ-1 wraps to 0.
  - NUM_REQ=1: the pointer is constant 0 and req_ready = req_valid.
  - Address values pass unmodified; signed-to-ROM-index offsetting is the ROM's job.

Test Plan:
- Reset then idle: rst=1 for 3 cycles with random req_valid -> req_ready, resp_valid, rom_x, busy all 0. After release with req_valid=0 -> all stay 0, ptr=0.
- Single request (ROM model: registered 1-cycle, out = x+100):
  - Stimulus: req_valid=4'b0100, req_x[2]=10'd37 in cycle 5.
  - Required: req_ready=4'b0100 in cycle 5; rom_x=37 in cycle 6; resp_valid=4'b0100 with resp_data=137 in cycle 8; busy high in cycles 6-7.
- Round-robin fairness: req_valid=4'b1111 held 8 cycles with req_x[i]=i -> grants 0,1,2,3,0,1,2,3. Responses in the same order, 3 cycles later, with data 100,101,102,103,...
- Pointer rotation with gaps:
  - Stimulus: grant to 3 (only valid), then req_valid=4'b1001.
  - Required: grant 0 (pointer wrapped to 0), then grant 3, then grant 0.
- Reset mid-flight:
  - Stimulus: two lookups accepted in cycles 5 and 6, rst pulsed asynchronously in cycle 7.
  - Required: no resp_valid pulse ever appears for them; busy=0 immediately.
- Back-to-back single requester, ROM_LAT=3: requester 1 issues x=5,6,7 in consecutive cycles -> resp_valid=4'b0010 in 3 consecutive cycles, each 5 cycles after acceptance, data 105,106,107.
